// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared FSM states and word/byte constants for the program loader
package instr_mem_loader_pkg;
  localparam int BYTE_WIDTH = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [63:0] HALT_WORD = '1;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;
endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// word_assembler: packs accepted bytes big-endian into words, pulses ready with the 4th byte
module word_assembler
  import instr_mem_loader_pkg::*;
#(
  parameter int NB_BYTE = BYTE_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              accept,
  input  logic [NB_BYTE-1:0]                data,
  output logic [BYTES_PER_WORD*NB_BYTE-1:0] word,
  output logic                              ready
);
  localparam int NB_SH = (BYTES_PER_WORD - 1) * NB_BYTE;
  logic [1:0]       cnt;
  logic [NB_SH-1:0] sh;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      sh  <= '0;
    end else if (clear) begin
      cnt <= '0;
      sh  <= '0;
    end else if (accept) begin
      cnt <= cnt + 2'd1;
      sh  <= {sh[NB_SH-NB_BYTE-1:0], data};
    end
  // the word is completed combinationally so the top can register it on the 4th byte's edge
  assign word  = {sh, data};
  assign ready = accept && cnt == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a UART byte stream into instruction memory, then releases the CPU
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int NB_DATA = BYTES_PER_WORD * BYTE_WIDTH,
  parameter int NB_ADDR = 10,
  parameter int NB_BYTE = BYTE_WIDTH
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_imem_wr_enb,
  output logic [NB_ADDR-1:0] o_imem_wr_addr,
  output logic [NB_DATA-1:0] o_imem_wr_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic               o_cpu_enb,
  output logic [NB_ADDR:0]   o_word_count
);
  localparam logic [NB_DATA-1:0] HALT = NB_DATA'(HALT_WORD);
  state_t               state, nxt;
  logic [NB_ADDR-1:0]   addr;
  logic [NB_DATA-1:0]   word;
  logic                 ready, arm, accept;
  assign arm    = i_start && state != ST_LOAD;
  assign accept = state == ST_LOAD && i_rx_valid && !i_start;
  // i_start in LOAD keeps the load running but throws away any partial word
  word_assembler #(.NB_BYTE(NB_BYTE)) u_asm (
    .clk   (i_clock),
    .rst   (i_reset),
    .clear (i_start),
    .accept(accept),
    .data  (i_rx_data),
    .word  (word),
    .ready (ready)
  );
  always_comb begin
    nxt = state;
    if (arm) nxt = ST_LOAD;
    else if (ready) nxt = word == HALT ? ST_DONE : &addr ? ST_ERROR : state;
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state          <= ST_IDLE;
      addr           <= '0;
      o_imem_wr_enb  <= 1'b0;
      o_imem_wr_addr <= '0;
      o_imem_wr_data <= '0;
      o_word_count   <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_overflow     <= 1'b0;
      o_cpu_enb      <= 1'b0;
    end else begin
      state         <= nxt;
      o_busy        <= nxt == ST_LOAD;
      o_done        <= nxt == ST_DONE;
      o_overflow    <= nxt == ST_ERROR;
      o_cpu_enb     <= nxt == ST_DONE;
      o_imem_wr_enb <= ready;
      if (arm) begin
        addr         <= '0;
        o_word_count <= '0;
      end else if (ready) begin
        o_imem_wr_addr <= addr;
        o_imem_wr_data <= word;
        addr           <= addr + NB_ADDR'(1);
        o_word_count   <= o_word_count + (NB_ADDR+1)'(1);
      end
    end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, meaning instruction word width.
REQ-002 The block SHALL have parameter NB_ADDR, default 10, meaning instruction memory word-address width (depth 2**NB_ADDR).
REQ-003 The block SHALL have parameter NB_BYTE, default 8, meaning serial byte width; NB_DATA = 4*NB_BYTE.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 i_clock  input  1  sole clock, rising edge.
REQ-006 i_reset  input  1  asynchronous, active-high reset.
REQ-007 i_start  input  1  single-cycle pulse that arms a new program load.
REQ-008 i_rx_data  input  NB_BYTE  byte from the UART receiver.
REQ-009 i_rx_valid  input  1  single-cycle strobe qualifying i_rx_data.
REQ-010 o_imem_wr_enb  output  1  instruction memory write strobe.
REQ-011 o_imem_wr_addr  output  NB_ADDR  instruction memory word address.
REQ-012 o_imem_wr_data  output  NB_DATA  instruction word to write.
REQ-013 o_busy  output  1  high while in LOAD.
REQ-014 o_done  output  1  high while in DONE.
REQ-015 o_overflow  output  1  high while in ERROR.
REQ-016 o_cpu_enb  output  1  processor allowed to fetch; high only in DONE.
REQ-017 o_word_count  output  NB_ADDR+1  number of words written in current/last load.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, DONE, ERROR; encoding from the shared package.
REQ-019 IDLE -> LOAD on i_start; DONE/ERROR -> LOAD on i_start; LOAD ignores i_start.
REQ-020 Entering LOAD SHALL clear byte counter, word address and o_word_count.
REQ-021 In LOAD each i_rx_valid SHALL accept one byte; bytes outside LOAD, including one coincident with the i_start that enters LOAD, SHALL be dropped.
REQ-022 Byte order SHALL be big-endian: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-023 Byte counter SHALL wrap 3 -> 0 on the 4th accepted byte.
REQ-024 o_imem_wr_enb SHALL pulse exactly one cycle, in the cycle after the 4th byte is accepted, with the assembled word on o_imem_wr_data and current word address on o_imem_wr_addr.
REQ-025 Word address SHALL increment by 1 and o_word_count by 1 in the write cycle.
REQ-026 o_imem_wr_addr/o_imem_wr_data SHALL hold their last values when o_imem_wr_enb is low.
REQ-027 A word equal to HALT (all ones) SHALL be written like any other word, then FSM SHALL go LOAD -> DONE in the same write cycle.
REQ-028 If the word at address 2**NB_ADDR-1 is written and is not HALT, FSM SHALL go LOAD -> ERROR in that write cycle; further bytes dropped.
REQ-029 A partial word (1-3 bytes) pending when i_start re-arms or reset occurs SHALL be discarded, never written.
REQ-030 i_rx_valid on consecutive cycles SHALL be accepted without loss (one byte per clock).

Reset
REQ-031 On i_reset: state IDLE; o_imem_wr_enb, o_busy, o_done, o_overflow, o_cpu_enb = 0; o_imem_wr_addr, o_imem_wr_data, o_word_count, byte counter, shift register = 0.
REQ-032 Reset mid-LOAD SHALL abort immediately with no write pulse issued after reset asserts.

Structure
REQ-033 Shared package SHALL hold FSM state localparams, HALT_WORD constant and NB_BYTE/bytes-per-word constant.
REQ-034 Byte-to-word assembly SHALL be one sub-module, word_assembler (shift register + byte counter + word-ready pulse); FSM and address counter in top.

Verification
REQ-035 i_start; bytes 20,01,00,05, FF,FF,FF,FF -> writes addr 0 = 32'h20010005, addr 1 = 32'hFFFFFFFF, o_done=1, o_cpu_enb=1, o_word_count=2.
REQ-036 4th byte on cycle N -> o_imem_wr_enb high only on cycle N+1; back-to-back bytes every cycle -> no loss, 3 words at addr 0,1,2.
REQ-037 NB_ADDR=2, 16 non-HALT bytes -> 4 writes addr 0..3, then o_overflow=1, o_busy=0, 17th byte produces no write.
REQ-038 Two bytes AA,BB then i_start -> no write; next 4 bytes 11,22,33,44 -> addr 0 = 32'h11223344.
REQ-039 i_reset asserted after 3rd byte of a word -> all outputs zero asynchronously, no write; bytes while IDLE ignored.
REQ-040 From DONE, i_start with coincident i_rx_valid -> byte dropped, o_word_count=0, o_cpu_enb=0, o_busy=1.
